// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline slice.
//   - ALU control encodings driven to the ALU
//   - fwd_sel_e: operand source chosen by the forwarding comparators
//   - ctrl_t / CTRL_BUBBLE: the registered ID/EX control word and its bubble
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_e;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       valid;
  } ctrl_t;

  // A bubble is a no-op AND with every side effect disabled.
  localparam ctrl_t CTRL_BUBBLE = '{alu_ctrl: ALU_AND, default: 1'b0};

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between ID, the forwarding sources and the ID/EX stage.
//   slave  : the ID/EX stage (consumes ID/forward inputs, drives ALU side)
//   master : the surrounding pipeline / testbench
interface id_ex_stage_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned REGW  = 3
);
  logic             stall_in;
  logic             flush_in;
  logic             valid_in;
  logic [WIDTH-1:0] rsData_in;
  logic [WIDTH-1:0] rtData_in;
  logic [WIDTH-1:0] imm_in;
  logic [REGW-1:0]  rs_in;
  logic [REGW-1:0]  rt_in;
  logic [REGW-1:0]  rd_in;
  logic [3:0]       aluCtrl_in;
  logic             aluSrc_in;
  logic             regDst_in;
  logic             regWrite_in;
  logic             memRead_in;
  logic             memWrite_in;
  logic             memToReg_in;
  logic             exmemRegWrite_in;
  logic [REGW-1:0]  exmemRd_in;
  logic [WIDTH-1:0] exmemData_in;
  logic             memwbRegWrite_in;
  logic [REGW-1:0]  memwbRd_in;
  logic [WIDTH-1:0] memwbData_in;

  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [3:0]       aluCtrl_out;
  logic [WIDTH-1:0] storeData_out;
  logic [REGW-1:0]  writeReg_out;
  logic             regWrite_out;
  logic             memRead_out;
  logic             memWrite_out;
  logic             memToReg_out;
  logic             valid_out;
  logic             hazard_out;

  modport slave (
    input  stall_in, flush_in, valid_in, rsData_in, rtData_in, imm_in,
           rs_in, rt_in, rd_in, aluCtrl_in, aluSrc_in, regDst_in,
           regWrite_in, memRead_in, memWrite_in, memToReg_in,
           exmemRegWrite_in, exmemRd_in, exmemData_in,
           memwbRegWrite_in, memwbRd_in, memwbData_in,
    output a_out, b_out, aluCtrl_out, storeData_out, writeReg_out,
           regWrite_out, memRead_out, memWrite_out, memToReg_out,
           valid_out, hazard_out
  );

  modport master (
    output stall_in, flush_in, valid_in, rsData_in, rtData_in, imm_in,
           rs_in, rt_in, rd_in, aluCtrl_in, aluSrc_in, regDst_in,
           regWrite_in, memRead_in, memWrite_in, memToReg_in,
           exmemRegWrite_in, exmemRd_in, exmemData_in,
           memwbRegWrite_in, memwbRd_in, memwbData_in,
    input  a_out, b_out, aluCtrl_out, storeData_out, writeReg_out,
           regWrite_out, memRead_out, memWrite_out, memToReg_out,
           valid_out, hazard_out
  );
endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: combinational source/destination comparator.
//   src_in            : source register of the operand being resolved
//   exmem_we_in/rd_in : EX/MEM write enable and destination
//   memwb_we_in/rd_in : MEM/WB write enable and destination
//   sel_out           : operand source; EX/MEM (younger) beats MEM/WB,
//                       r0 is never forwarded
module forward_unit
  import mips_pkg::*;
#(
  parameter int unsigned REGW = 3
) (
  input  logic [REGW-1:0] src_in,
  input  logic            exmem_we_in,
  input  logic [REGW-1:0] exmem_rd_in,
  input  logic            memwb_we_in,
  input  logic [REGW-1:0] memwb_rd_in,
  output fwd_sel_e        sel_out
);

  always_comb begin
    sel_out = FWD_REG;
    if (src_in != '0) begin
      if (exmem_we_in && (exmem_rd_in == src_in)) begin
        sel_out = FWD_EXMEM;
      end else if (memwb_we_in && (memwb_rd_in == src_in)) begin
        sel_out = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding.
//   clock_in : rising-edge clock
//   reset_in : synchronous active-high reset (loads a bubble)
//   bus      : id_ex_stage_if.slave -- ID operands/control, stall/flush,
//              EX/MEM and MEM/WB forwarding sources, ALU operands/control,
//              registered control and the load-use hazard flag
// Edge priority: reset > flush > stall > load.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned REGW  = 3
) (
  input  logic          clock_in,
  input  logic          reset_in,
  id_ex_stage_if.slave  bus
);

  ctrl_t            ctrl_q;
  logic [REGW-1:0]  rs_q;
  logic [REGW-1:0]  rt_q;
  logic [REGW-1:0]  write_reg_q;
  logic [WIDTH-1:0] rs_data_q;
  logic [WIDTH-1:0] rt_data_q;
  logic [WIDTH-1:0] imm_q;

  fwd_sel_e         sel_a;
  fwd_sel_e         sel_b;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;

  forward_unit #(.REGW(REGW)) u_fwd_rs (
    .src_in      (rs_q),
    .exmem_we_in (bus.exmemRegWrite_in),
    .exmem_rd_in (bus.exmemRd_in),
    .memwb_we_in (bus.memwbRegWrite_in),
    .memwb_rd_in (bus.memwbRd_in),
    .sel_out     (sel_a)
  );

  forward_unit #(.REGW(REGW)) u_fwd_rt (
    .src_in      (rt_q),
    .exmem_we_in (bus.exmemRegWrite_in),
    .exmem_rd_in (bus.exmemRd_in),
    .memwb_we_in (bus.memwbRegWrite_in),
    .memwb_rd_in (bus.memwbRd_in),
    .sel_out     (sel_b)
  );

  always_comb begin
    fwd_a = rs_data_q;
    unique case (sel_a)
      FWD_EXMEM: fwd_a = bus.exmemData_in;
      FWD_MEMWB: fwd_a = bus.memwbData_in;
      default:   fwd_a = rs_data_q;
    endcase
  end

  always_comb begin
    fwd_b = rt_data_q;
    unique case (sel_b)
      FWD_EXMEM: fwd_b = bus.exmemData_in;
      FWD_MEMWB: fwd_b = bus.memwbData_in;
      default:   fwd_b = rt_data_q;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in || bus.flush_in) begin
      ctrl_q      <= CTRL_BUBBLE;
      rs_q        <= '0;
      rt_q        <= '0;
      write_reg_q <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
    end else if (bus.stall_in) begin
      // Fold the current forwarded values into the held operands so a
      // producer that retires from MEM/WB during the stall is not lost.
      rs_data_q <= fwd_a;
      rt_data_q <= fwd_b;
    end else begin
      ctrl_q <= '{alu_ctrl:   bus.aluCtrl_in,
                  alu_src:    bus.aluSrc_in,
                  reg_write:  bus.regWrite_in,
                  mem_read:   bus.memRead_in,
                  mem_write:  bus.memWrite_in,
                  mem_to_reg: bus.memToReg_in,
                  valid:      bus.valid_in};
      rs_q        <= bus.rs_in;
      rt_q        <= bus.rt_in;
      write_reg_q <= bus.regDst_in ? bus.rd_in : bus.rt_in;
      rs_data_q   <= bus.rsData_in;
      rt_data_q   <= bus.rtData_in;
      imm_q       <= bus.imm_in;
    end
  end

  assign bus.a_out         = fwd_a;
  assign bus.b_out         = ctrl_q.alu_src ? imm_q : fwd_b;
  assign bus.storeData_out = fwd_b;
  assign bus.aluCtrl_out   = ctrl_q.alu_ctrl;
  assign bus.writeReg_out  = write_reg_q;
  assign bus.regWrite_out  = ctrl_q.reg_write;
  assign bus.memRead_out   = ctrl_q.mem_read;
  assign bus.memWrite_out  = ctrl_q.mem_write;
  assign bus.memToReg_out  = ctrl_q.mem_to_reg;
  assign bus.valid_out     = ctrl_q.valid;

  // Load in EX whose destination is read by the instruction now in ID.
  assign bus.hazard_out = ctrl_q.valid && ctrl_q.mem_read &&
                          (write_reg_q != '0) &&
                          ((write_reg_q == bus.rs_in) || (write_reg_q == bus.rt_in));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import mips_pkg::*;

  logic clock_in = 1'b0;
  logic reset_in = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  always #5 clock_in = ~clock_in;

  id_ex_stage_if #(.WIDTH(16), .REGW(3)) bus ();

  id_ex_stage #(.WIDTH(16), .REGW(3)) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  // Reference: the instruction record held in the stage.
  typedef struct {
    logic [2:0]  rs, rt, wr;
    logic [15:0] rsd, rtd, imm;
    logic [3:0]  alu;
    logic        src, rw, mr, mw, m2r, v;
  } model_t;

  model_t m;

  // Value an operand sees: youngest matching producer, else held data.
  function automatic logic [15:0] resolve(input logic [2:0] src, input logic [15:0] held);
    if (src == 3'd0) return held;
    if (bus.exmemRegWrite_in && bus.exmemRd_in == src) return bus.exmemData_in;
    if (bus.memwbRegWrite_in && bus.memwbRd_in == src) return bus.memwbData_in;
    return held;
  endfunction

  function automatic logic [63:0] exp_vec();
    logic [15:0] fa, fb;
    logic        haz;
    fa  = resolve(m.rs, m.rsd);
    fb  = resolve(m.rt, m.rtd);
    haz = m.v && m.mr && (m.wr != 3'd0) && ((m.wr == bus.rs_in) || (m.wr == bus.rt_in));
    return {3'b000, fa, (m.src ? m.imm : fb), fb, m.alu, m.wr,
            m.rw, m.mr, m.mw, m.m2r, m.v, haz};
  endfunction

  function automatic logic [63:0] obs_vec();
    return {3'b000, bus.a_out, bus.b_out, bus.storeData_out, bus.aluCtrl_out,
            bus.writeReg_out, bus.regWrite_out, bus.memRead_out, bus.memWrite_out,
            bus.memToReg_out, bus.valid_out, bus.hazard_out};
  endfunction

  task automatic tick();
    model_t n;
    @(posedge clock_in);
    n = m;
    if (reset_in || bus.flush_in) begin
      n = '{rs: 0, rt: 0, wr: 0, rsd: 0, rtd: 0, imm: 0, alu: 0,
            src: 0, rw: 0, mr: 0, mw: 0, m2r: 0, v: 0};
    end else if (bus.stall_in) begin
      n.rsd = resolve(m.rs, m.rsd);
      n.rtd = resolve(m.rt, m.rtd);
    end else begin
      n.rs  = bus.rs_in;
      n.rt  = bus.rt_in;
      n.wr  = bus.regDst_in ? bus.rd_in : bus.rt_in;
      n.rsd = bus.rsData_in;
      n.rtd = bus.rtData_in;
      n.imm = bus.imm_in;
      n.alu = bus.aluCtrl_in;
      n.src = bus.aluSrc_in;
      n.rw  = bus.regWrite_in;
      n.mr  = bus.memRead_in;
      n.mw  = bus.memWrite_in;
      n.m2r = bus.memToReg_in;
      n.v   = bus.valid_in;
    end
    m = n;
    #1;
  endtask

  task automatic drive_idle();
    bus.stall_in = 0; bus.flush_in = 0; bus.valid_in = 0;
    bus.rsData_in = 0; bus.rtData_in = 0; bus.imm_in = 0;
    bus.rs_in = 0; bus.rt_in = 0; bus.rd_in = 0; bus.aluCtrl_in = 0;
    bus.aluSrc_in = 0; bus.regDst_in = 0; bus.regWrite_in = 0;
    bus.memRead_in = 0; bus.memWrite_in = 0; bus.memToReg_in = 0;
    bus.exmemRegWrite_in = 0; bus.exmemRd_in = 0; bus.exmemData_in = 0;
    bus.memwbRegWrite_in = 0; bus.memwbRd_in = 0; bus.memwbData_in = 0;
  endtask

  task automatic test_reset();
    bus.stall_in = 1; bus.flush_in = 1; bus.valid_in = 1;
    bus.rsData_in = 16'hA5A5; bus.rtData_in = 16'h5A5A; bus.imm_in = 16'h0F0F;
    bus.rs_in = 3'd1; bus.rt_in = 3'd2; bus.rd_in = 3'd3; bus.aluCtrl_in = ALU_NOR;
    bus.aluSrc_in = 1; bus.regDst_in = 1; bus.regWrite_in = 1;
    bus.memRead_in = 1; bus.memWrite_in = 1; bus.memToReg_in = 1;
    bus.exmemRegWrite_in = 1; bus.exmemRd_in = 3'd1; bus.exmemData_in = 16'h1111;
    bus.memwbRegWrite_in = 1; bus.memwbRd_in = 3'd2; bus.memwbData_in = 16'h2222;
    reset_in = 1;
    tick();
    tick();
    reset_in = 0;
    bus.valid_in = 0; bus.stall_in = 0; bus.flush_in = 0;
    bus.exmemRegWrite_in = 0; bus.memwbRegWrite_in = 0;
    #1;
    checks++;
    if (obs_vec() !== 64'd0) begin
      errors++; $display("FAIL reset_all_zero: got %h expected %h", obs_vec(), 64'd0);
    end
    checks++;
    if (bus.hazard_out !== 1'b0) begin
      errors++; $display("FAIL reset_hazard: got %b expected 0", bus.hazard_out);
    end
  endtask

  task automatic test_load();
    drive_idle();
    bus.valid_in = 1; bus.rs_in = 3'd1; bus.rt_in = 3'd2; bus.rd_in = 3'd6;
    bus.rsData_in = 16'h0005; bus.rtData_in = 16'h0003; bus.aluCtrl_in = ALU_SUB;
    bus.regDst_in = 1; bus.regWrite_in = 1;
    tick();
    checks++;
    if (bus.a_out !== 16'h0005) begin
      errors++; $display("FAIL load_a: got %h expected %h", bus.a_out, 16'h0005);
    end
    checks++;
    if (bus.b_out !== 16'h0003) begin
      errors++; $display("FAIL load_b: got %h expected %h", bus.b_out, 16'h0003);
    end
    checks++;
    if (bus.aluCtrl_out !== 4'b0110 || bus.writeReg_out !== 3'd6 || bus.valid_out !== 1'b1) begin
      errors++; $display("FAIL load_ctrl: got alu=%b wr=%0d v=%b expected alu=0110 wr=6 v=1",
                         bus.aluCtrl_out, bus.writeReg_out, bus.valid_out);
    end
    // regDst = 0 selects rt as the destination
    bus.regDst_in = 0;
    tick();
    checks++;
    if (bus.writeReg_out !== 3'd2) begin
      errors++; $display("FAIL load_regdst_rt: got %0d expected 2", bus.writeReg_out);
    end
  endtask

  task automatic test_forward();
    drive_idle();
    bus.valid_in = 1; bus.rs_in = 3'd3; bus.rt_in = 3'd3;
    bus.rsData_in = 16'h0011; bus.rtData_in = 16'h0012; bus.imm_in = 16'h7777;
    bus.aluSrc_in = 1;
    tick();
    bus.exmemRegWrite_in = 1; bus.exmemRd_in = 3'd3; bus.exmemData_in = 16'h00AA;
    bus.memwbRegWrite_in = 1; bus.memwbRd_in = 3'd3; bus.memwbData_in = 16'h00BB;
    #1;
    checks++;
    if (bus.a_out !== 16'h00AA) begin
      errors++; $display("FAIL fwd_exmem_priority: got %h expected %h", bus.a_out, 16'h00AA);
    end
    checks++;
    if (bus.b_out !== 16'h7777 || bus.storeData_out !== 16'h00AA) begin
      errors++; $display("FAIL fwd_imm_store: got b=%h st=%h expected b=7777 st=00aa",
                         bus.b_out, bus.storeData_out);
    end
    bus.exmemRegWrite_in = 0;
    #1;
    checks++;
    if (bus.a_out !== 16'h00BB) begin
      errors++; $display("FAIL fwd_memwb: got %h expected %h", bus.a_out, 16'h00BB);
    end
    bus.rs_in = 3'd0; bus.rsData_in = 16'h0022;
    bus.exmemRegWrite_in = 1; bus.exmemRd_in = 3'd0;
    bus.memwbRd_in = 3'd0;
    tick();
    checks++;
    if (bus.a_out !== 16'h0022) begin
      errors++; $display("FAIL fwd_r0_never: got %h expected %h", bus.a_out, 16'h0022);
    end
  endtask

  task automatic test_load_use();
    drive_idle();
    bus.valid_in = 1; bus.memRead_in = 1; bus.regDst_in = 0; bus.rt_in = 3'd4;
    bus.rd_in = 3'd7; bus.regWrite_in = 1; bus.memToReg_in = 1; bus.aluCtrl_in = ALU_ADD;
    tick();
    bus.rs_in = 3'd5; bus.rt_in = 3'd6;
    #1;
    checks++;
    if (bus.hazard_out !== 1'b0) begin
      errors++; $display("FAIL hazard_no_match: got %b expected 0", bus.hazard_out);
    end
    bus.rs_in = 3'd4;
    #1;
    checks++;
    if (bus.hazard_out !== 1'b1 || bus.writeReg_out !== 3'd4) begin
      errors++; $display("FAIL hazard_rs_match: got haz=%b wr=%0d expected haz=1 wr=4",
                         bus.hazard_out, bus.writeReg_out);
    end
    bus.flush_in = 1;
    tick();
    bus.flush_in = 0;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.memRead_out !== 1'b0 || bus.regWrite_out !== 1'b0 ||
        bus.memToReg_out !== 1'b0 || bus.aluCtrl_out !== 4'd0 || bus.hazard_out !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: got v=%b mr=%b rw=%b m2r=%b alu=%b haz=%b expected all 0",
                         bus.valid_out, bus.memRead_out, bus.regWrite_out,
                         bus.memToReg_out, bus.aluCtrl_out, bus.hazard_out);
    end
  endtask

  task automatic test_stall();
    drive_idle();
    bus.valid_in = 1; bus.rs_in = 3'd5; bus.rsData_in = 16'h0099;
    bus.aluCtrl_in = ALU_OR; bus.regWrite_in = 1; bus.regDst_in = 1; bus.rd_in = 3'd2;
    tick();
    bus.memwbRegWrite_in = 1; bus.memwbRd_in = 3'd5; bus.memwbData_in = 16'h1234;
    // ID now presents different content that must not be captured
    bus.rs_in = 3'd1; bus.rsData_in = 16'hDEAD; bus.aluCtrl_in = ALU_NOR; bus.valid_in = 0;
    bus.stall_in = 1;
    #1;
    checks++;
    if (bus.a_out !== 16'h1234) begin
      errors++; $display("FAIL stall_fwd_pre: got %h expected %h", bus.a_out, 16'h1234);
    end
    tick();
    bus.memwbRegWrite_in = 0;
    tick();
    checks++;
    if (bus.a_out !== 16'h1234) begin
      errors++; $display("FAIL stall_keeps_fwd: got %h expected %h", bus.a_out, 16'h1234);
    end
    checks++;
    if (bus.aluCtrl_out !== ALU_OR || bus.valid_out !== 1'b1 || bus.writeReg_out !== 3'd2 ||
        bus.regWrite_out !== 1'b1) begin
      errors++; $display("FAIL stall_holds_ctrl: got alu=%b v=%b wr=%0d rw=%b expected alu=0001 v=1 wr=2 rw=1",
                         bus.aluCtrl_out, bus.valid_out, bus.writeReg_out, bus.regWrite_out);
    end
    bus.stall_in = 0;
  endtask

  task automatic test_stall_flush();
    drive_idle();
    bus.valid_in = 1; bus.rs_in = 3'd1; bus.rsData_in = 16'h4444; bus.regWrite_in = 1;
    bus.aluCtrl_in = ALU_SLT; bus.memWrite_in = 1;
    tick();
    bus.stall_in = 1; bus.flush_in = 1;
    tick();
    bus.flush_in = 0;
    checks++;
    if (obs_vec() !== 64'd0) begin
      errors++; $display("FAIL stall_flush_bubble: got %h expected %h", obs_vec(), 64'd0);
    end
    bus.stall_in = 0;
    tick();
    bus.stall_in = 1;
    tick();
    reset_in = 1;
    tick();
    reset_in = 0;
    checks++;
    if (obs_vec() !== 64'd0) begin
      errors++; $display("FAIL reset_mid_stall: got %h expected %h", obs_vec(), 64'd0);
    end
    bus.stall_in = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset_in          = ($urandom_range(0, 31) == 0);
      bus.flush_in      = ($urandom_range(0, 7) == 0);
      bus.stall_in      = ($urandom_range(0, 3) == 0);
      bus.valid_in      = $urandom_range(0, 1);
      bus.rsData_in     = 16'($urandom);
      bus.rtData_in     = 16'($urandom);
      bus.imm_in        = 16'($urandom);
      bus.rs_in         = 3'($urandom_range(0, 7));
      bus.rt_in         = 3'($urandom_range(0, 7));
      bus.rd_in         = 3'($urandom_range(0, 7));
      bus.aluCtrl_in    = 4'($urandom);
      bus.aluSrc_in     = $urandom_range(0, 1);
      bus.regDst_in     = $urandom_range(0, 1);
      bus.regWrite_in   = $urandom_range(0, 1);
      bus.memRead_in    = $urandom_range(0, 1);
      bus.memWrite_in   = $urandom_range(0, 1);
      bus.memToReg_in   = $urandom_range(0, 1);
      bus.exmemRegWrite_in = $urandom_range(0, 1);
      bus.exmemRd_in    = 3'($urandom_range(0, 7));
      bus.exmemData_in  = 16'($urandom);
      bus.memwbRegWrite_in = $urandom_range(0, 1);
      bus.memwbRd_in    = 3'($urandom_range(0, 7));
      bus.memwbData_in  = 16'($urandom);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_edge[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
      // Change only combinational inputs mid-cycle
      bus.exmemRegWrite_in = $urandom_range(0, 1);
      bus.exmemRd_in    = 3'($urandom_range(0, 7));
      bus.memwbRegWrite_in = $urandom_range(0, 1);
      bus.memwbRd_in    = 3'($urandom_range(0, 7));
      bus.rs_in         = 3'($urandom_range(0, 7));
      bus.rt_in         = 3'($urandom_range(0, 7));
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_comb[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    reset_in = 0;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_load();
    test_forward();
    test_load_use();
    test_stall();
    test_stall_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
